// File: rtl/hline_burst_engine_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : hline_burst_engine_if
//  Brief    : AXI4 read/write channel bundle used by hline_burst_engine
//  Revision : 1.0  initial release
// ============================================================================
interface hline_burst_engine_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/hline_burst_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : hline_burst_engine
//  Brief    : Single-burst AXI4 mover between a line address and the pcore
//             FIFOs. Define ERR_CHECK_EN to enable the sticky axi_err flag.
//  Revision : 1.0  initial release
// ============================================================================
module hline_burst_engine #(
    parameter int BURST_LEN = 256,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [31:0]         addr,
    output logic                axi_done,
    output logic [DATA_W-1:0]   fifo_wdata,
    output logic                fifo_wr,
    input  logic                fifo_full,
    input  logic [DATA_W-1:0]   fifo_rdata,
    output logic                fifo_rd,
    input  logic                fifo_empty,
    output logic                axi_err,
    hline_burst_engine_if.master m_axi
);

    localparam logic [7:0] c_AXI_LEN   = 8'(BURST_LEN - 1);
    localparam logic [8:0] c_LAST_BEAT = 9'(BURST_LEN - 1);
    localparam logic [2:0] c_AXI_SIZE  = 3'b010;
    localparam logic [1:0] c_AXI_INCR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_DATA = 3'd4,
        S_WR_RESP = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [8:0]  r_beat;
    logic        w_accept;
    logic        w_r_hs;
    logic        w_w_hs;
    logic        w_last_beat;
    logic        w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && (rd_req || wr_req);
    assign w_r_hs        = m_axi.rvalid && m_axi.rready;
    assign w_w_hs        = m_axi.wvalid && m_axi.wready;
    assign w_last_beat   = (r_beat == c_LAST_BEAT);
    assign w_unused_addr = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= {addr[31:2], 2'b00};
                r_beat <= '0;
            end else if (w_r_hs || w_w_hs) begin
                r_beat <= r_beat + 9'd1;
            end
        end
    end

    // Every channel output is forced to zero outside the state that owns it.
    always_comb begin
        w_next          = r_state;
        m_axi.araddr    = '0;
        m_axi.arlen     = '0;
        m_axi.arsize    = '0;
        m_axi.arburst   = '0;
        m_axi.arvalid   = 1'b0;
        m_axi.rready    = 1'b0;
        m_axi.awaddr    = '0;
        m_axi.awlen     = '0;
        m_axi.awsize    = '0;
        m_axi.awburst   = '0;
        m_axi.awvalid   = 1'b0;
        m_axi.wdata     = '0;
        m_axi.wstrb     = '0;
        m_axi.wlast     = 1'b0;
        m_axi.wvalid    = 1'b0;
        m_axi.bready    = 1'b0;
        fifo_wdata      = '0;
        fifo_wr         = 1'b0;
        fifo_rd         = 1'b0;
        axi_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rd_req) begin
                    w_next = S_RD_ADDR;
                end else if (wr_req) begin
                    w_next = S_WR_ADDR;
                end
            end
            S_RD_ADDR: begin
                m_axi.araddr  = r_addr;
                m_axi.arlen   = c_AXI_LEN;
                m_axi.arsize  = c_AXI_SIZE;
                m_axi.arburst = c_AXI_INCR;
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                m_axi.rready = !fifo_full;
                fifo_wr      = m_axi.rvalid && !fifo_full;
                fifo_wdata   = m_axi.rdata;
                if (m_axi.rvalid && !fifo_full && m_axi.rlast) begin
                    w_next = S_DONE;
                end
            end
            S_WR_ADDR: begin
                m_axi.awaddr  = r_addr;
                m_axi.awlen   = c_AXI_LEN;
                m_axi.awsize  = c_AXI_SIZE;
                m_axi.awburst = c_AXI_INCR;
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) begin
                    w_next = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                m_axi.wvalid = !fifo_empty;
                m_axi.wdata  = fifo_rdata;
                m_axi.wstrb  = 4'hF;
                m_axi.wlast  = w_last_beat;
                fifo_rd      = !fifo_empty && m_axi.wready;
                if (!fifo_empty && m_axi.wready && w_last_beat) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                axi_done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef ERR_CHECK_EN
    logic r_err;
    logic w_b_hs;

    assign w_b_hs = m_axi.bvalid && m_axi.bready;

    // rlast must coincide exactly with the final counted beat; any skew is an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_r_hs && ((m_axi.rresp != 2'b00) || (m_axi.rlast != w_last_beat))) begin
            r_err <= 1'b1;
        end else if (w_b_hs && (m_axi.bresp != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

    assign axi_err = r_err;
`else
    logic w_unused_resp;

    assign w_unused_resp = ^{m_axi.rresp, m_axi.bresp};
    assign axi_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hline_burst_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hline_burst_engine
//  Brief    : Directed bench for hline_burst_engine with AXI slave/FIFO model
//  Revision : 1.0  initial release
// ============================================================================
module tb_hline_burst_engine;

    localparam int BL = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic        axi_done;
    logic [31:0] fifo_wdata;
    logic        fifo_wr;
    logic        fifo_full;
    logic [31:0] fifo_rdata;
    logic        fifo_rd;
    logic        fifo_empty;
    logic        axi_err;

    hline_burst_engine_if m_axi();

    hline_burst_engine #(.BURST_LEN(BL), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .axi_done   (axi_done),
        .fifo_wdata (fifo_wdata),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .axi_err    (axi_err),
        .m_axi      (m_axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave/FIFO model state
    logic [1:0]  rresp_k = 2'b00;
    logic [1:0]  bresp_k = 2'b00;
    bit          gap_mode = 1'b0;
    bit          rd_active;
    bit          b_pend;
    int          rd_idx;
    logic [31:0] out_q[$];
    logic [31:0] rd_cap[$];
    logic [31:0] wr_cap[$];
    int          wlast_cnt, wlast_bad, wstrb_bad, done_cnt, ar_cnt, aw_cnt;
    int          ar_cyc, aw_cyc, w_first_cyc;
    logic [31:0] ar_addr_s, aw_addr_s;
    logic [7:0]  ar_len_s, aw_len_s;
    logic [2:0]  ar_size_s, aw_size_s;
    logic [1:0]  ar_burst_s, aw_burst_s;

    initial begin
        bit rs, ar_hs, r_hs, aw_hs, w_hs, w_last, b_hs, frd;
        rd_active = 0; b_pend = 0; rd_idx = 0;
        wlast_cnt = 0; wlast_bad = 0; wstrb_bad = 0; done_cnt = 0; ar_cnt = 0; aw_cnt = 0;
        m_axi.arready = 1'b1; m_axi.awready = 1'b1; m_axi.wready = 1'b1;
        m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rlast = 1'b0; m_axi.rresp = '0;
        m_axi.bvalid = 1'b0; m_axi.bresp = '0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        forever begin
            @(negedge clk);
            rs     = reset;
            ar_hs  = m_axi.arvalid && m_axi.arready;
            r_hs   = m_axi.rvalid && m_axi.rready;
            aw_hs  = m_axi.awvalid && m_axi.awready;
            w_hs   = m_axi.wvalid && m_axi.wready;
            w_last = m_axi.wlast;
            b_hs   = m_axi.bvalid && m_axi.bready;
            frd    = fifo_rd;
            if (!rs) begin
                if (ar_hs) begin
                    ar_cnt++; ar_cyc = cyc; ar_addr_s = m_axi.araddr; ar_len_s = m_axi.arlen;
                    ar_size_s = m_axi.arsize; ar_burst_s = m_axi.arburst;
                end
                if (aw_hs) begin
                    aw_cnt++; aw_cyc = cyc; aw_addr_s = m_axi.awaddr; aw_len_s = m_axi.awlen;
                    aw_size_s = m_axi.awsize; aw_burst_s = m_axi.awburst;
                end
                if (fifo_wr) rd_cap.push_back(fifo_wdata);
                if (w_hs) begin
                    if (wr_cap.size() == 0) w_first_cyc = cyc;
                    wr_cap.push_back(m_axi.wdata);
                    if (m_axi.wstrb != 4'hF) wstrb_bad++;
                    if (w_last) begin
                        wlast_cnt++;
                        if (wr_cap.size() != BL) wlast_bad++;
                    end
                end
                if (axi_done) done_cnt++;
            end
            @(posedge clk); #1;
            if (rs) begin
                rd_active = 0; b_pend = 0; out_q.delete();
            end else begin
                if (ar_hs) begin rd_active = 1; rd_idx = 0; end
                if (r_hs) begin
                    if (rd_idx == BL - 1) rd_active = 0;
                    rd_idx++;
                end
                if (frd && out_q.size() > 0) void'(out_q.pop_front());
                if (w_hs && w_last) b_pend = 1;
                if (b_hs) b_pend = 0;
            end
            m_axi.rvalid = rd_active;
            m_axi.rdata  = 32'(rd_idx);
            m_axi.rlast  = rd_active && (rd_idx == BL - 1);
            m_axi.rresp  = rresp_k;
            m_axi.bvalid = b_pend;
            m_axi.bresp  = bresp_k;
            fifo_empty   = (out_q.size() == 0) || (gap_mode && (cyc % 5 == 0));
            fifo_rdata   = (out_q.size() > 0) ? out_q[0] : 32'h0;
        end
    end

    function automatic logic [31:0] outs_word();
        return {22'h0, m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready,
                fifo_wr, fifo_rd, axi_done, axi_err,
                |{m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.awaddr, m_axi.awlen,
                  m_axi.awsize, m_axi.awburst, m_axi.wdata, m_axi.wstrb, m_axi.wlast, fifo_wdata}};
    endfunction

    function automatic int bad_words(input logic [31:0] q[$], input logic [31:0] base);
        int b = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== base + 32'(i)) b++;
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] base);
        for (int i = 0; i < BL; i++) out_q.push_back(base + 32'(i));
        wr_cap.delete(); wlast_cnt = 0; wlast_bad = 0; wstrb_bad = 0;
        tick(2);
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, output int rc);
        rd_req = rd; wr_req = wr; addr = a; rc = cyc;
        tick(1);
        rd_req = 1'b0; wr_req = 1'b0; addr = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int rc, output bit ok, output int lat, output logic err);
        ok = 0; lat = -1; err = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (axi_done) begin ok = 1; lat = cyc - rc; err = axi_err; end
        end
        tick(1);
    endtask

    initial begin
        int rc, lat, d0, a0;
        bit ok, seen;
        logic err, act;

        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; fifo_full = 1'b0;
        tick(3);
        @(negedge clk);
        check_val("reset_outputs", outs_word(), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Read burst from 0x1000, plus a late write request that must be ignored
        rd_cap.delete(); d0 = done_cnt;
        do_req(1, 0, 32'h1000, rc);
        wr_req = 1'b1; tick(1); wr_req = 1'b0;
        wait_done(rc, ok, lat, err);
        check_val("rd_done_seen", 32'(ok), 1);
        check_val("rd_latency", 32'(lat), 258);
        @(negedge clk);
        check_val("rd_done_one_cycle", 32'(axi_done), 0);
        tick(2);
        check_val("rd_araddr", ar_addr_s, 32'h1000);
        check_val("rd_arlen", 32'(ar_len_s), 32'hFF);
        check_val("rd_arsize", 32'(ar_size_s), 2);
        check_val("rd_arburst", 32'(ar_burst_s), 1);
        check_val("rd_beats", 32'(rd_cap.size()), 256);
        check_val("rd_data_bad", 32'(bad_words(rd_cap, 32'h0)), 0);
        check_val("rd_done_count", 32'(done_cnt - d0), 1);
        check_val("rd_no_aw", 32'(aw_cnt), 0);

        // Write burst to 0x2003 (low bits dropped)
        preload(32'hA500_0000); d0 = done_cnt;
        do_req(0, 1, 32'h2003, rc);
        wait_done(rc, ok, lat, err);
        check_val("wr_done_seen", 32'(ok), 1);
        check_val("wr_latency", 32'(lat), 259);
        tick(2);
        check_val("wr_awaddr", aw_addr_s, 32'h2000);
        check_val("wr_awlen", 32'(aw_len_s), 32'hFF);
        check_val("wr_awsize_burst", {27'h0, aw_size_s, aw_burst_s}, {27'h0, 3'b010, 2'b01});
        check_val("wr_beats", 32'(wr_cap.size()), 256);
        check_val("wr_data_bad", 32'(bad_words(wr_cap, 32'hA500_0000)), 0);
        check_val("wr_wlast_count", 32'(wlast_cnt), 1);
        check_val("wr_wlast_misplaced", 32'(wlast_bad), 0);
        check_val("wr_wstrb_bad", 32'(wstrb_bad), 0);
        check_val("wr_w_after_aw", 32'(w_first_cyc > aw_cyc), 1);
        check_val("wr_done_count", 32'(done_cnt - d0), 1);
        check_val("wr_axi_err", 32'(axi_err), 0);

        // Simultaneous requests: read first, write only in a later IDLE
        preload(32'hB600_0000); rd_cap.delete(); a0 = aw_cnt;
        rd_req = 1'b1; wr_req = 1'b1; addr = 32'h3000; rc = cyc;
        tick(1);
        rd_req = 1'b0;
        wait_done(rc, ok, lat, err);
        check_val("both_rd_done", 32'(ok), 1);
        check_val("both_rd_addr", ar_addr_s, 32'h3000);
        check_val("both_no_aw_during_rd", 32'(aw_cnt - a0), 0);
        for (int i = 0; i < 10 && aw_cnt == a0; i++) tick(1);
        wr_req = 1'b0;
        check_val("both_aw_after_done", 32'(aw_cyc > rc + lat), 1);
        wait_done(aw_cyc, ok, lat, err);
        check_val("both_wr_done", 32'(ok), 1);
        tick(2);
        check_val("both_wr_data_bad", 32'(bad_words(wr_cap, 32'hB600_0000) + (wr_cap.size() != BL)), 0);

        // Read with a 10-cycle fifo_full stall
        rd_cap.delete();
        do_req(1, 0, 32'h4000, rc);
        for (int i = 0; i < 300 && rd_cap.size() < 50; i++) tick(1);
        fifo_full = 1'b1;
        tick(1);
        @(negedge clk);
        check_val("stall_rready_low", {30'h0, m_axi.rready, fifo_wr}, 0);
        tick(9);
        fifo_full = 1'b0;
        wait_done(rc, ok, lat, err);
        check_val("stall_rd_done", 32'(ok), 1);
        tick(1);
        check_val("stall_rd_beats", 32'(rd_cap.size()), 256);
        check_val("stall_rd_data_bad", 32'(bad_words(rd_cap, 32'h0)), 0);

        // Write with periodic fifo_empty gaps
        preload(32'hC700_0000); gap_mode = 1'b1;
        do_req(0, 1, 32'h5000, rc);
        tick(3);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (fifo_empty) begin
                seen = 1;
                check_val("gap_wvalid_low", {30'h0, m_axi.wvalid, fifo_rd}, 0);
            end
        end
        check_val("gap_seen", 32'(seen), 1);
        tick(1);
        wait_done(rc, ok, lat, err);
        gap_mode = 1'b0;
        check_val("gap_wr_done", 32'(ok), 1);
        tick(2);
        check_val("gap_wr_beats", 32'(wr_cap.size()), 256);
        check_val("gap_wr_data_bad", 32'(bad_words(wr_cap, 32'hC700_0000)), 0);
        check_val("gap_wlast_misplaced", 32'(wlast_bad + (wlast_cnt != 1)), 0);

        // Reset in the middle of a write
        preload(32'hD800_0000); d0 = done_cnt;
        do_req(0, 1, 32'h6000, rc);
        for (int i = 0; i < 400 && wr_cap.size() < 100; i++) tick(1);
        check_val("rst_beat_reached", 32'(wr_cap.size() >= 100), 1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check_val("rst_mid_outputs", outs_word(), 32'h0);
        tick(1);
        reset = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            act |= m_axi.arvalid | m_axi.awvalid | m_axi.wvalid | m_axi.rready | m_axi.bready | fifo_rd | axi_done;
        end
        check_val("rst_no_resume", 32'(act), 0);
        check_val("rst_no_done", 32'(done_cnt - d0), 0);
        tick(1);

        // Error response on the write response channel
        preload(32'hE900_0000); bresp_k = 2'b10;
        do_req(0, 1, 32'h7000, rc);
        wait_done(rc, ok, lat, err);
        bresp_k = 2'b00;
        check_val("err_done_seen", 32'(ok), 1);
`ifdef ERR_CHECK_EN
        check_val("err_flag_at_done", 32'(err), 1);
        tick(3);
        check_val("err_flag_sticky", 32'(axi_err), 1);
`else
        check_val("err_flag_tied_low", 32'(err), 0);
        tick(3);
`endif
        do_req(1, 0, 32'h8000, rc);
        @(negedge clk);
        check_val("err_cleared_on_accept", 32'(axi_err), 0);
        wait_done(rc, ok, lat, err);
        check_val("err_next_done", 32'(ok), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
